// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants for the write-back path
// Holds register-file geometry, the x0 index and requester index assignments.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MISC = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   PTR_W    requester with highest priority this cycle
//   grant     out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx out  PTR_W    index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    int   j;
    logic found;

    // Walk ptr, ptr+1, ... modulo NUM_REQ; the first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back port arbiter with pending-write scoreboard
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_addr/req_data per-requester write requests (packed, i*W +: W)
//   req_ready                  one-hot grant; accept = req_valid & req_ready
//   wr_en/wr_addr/wr_data      registered register-file write port
//   sb_set_valid/sb_set_addr   decode marks a destination register pending
//   sb_pending                 per-register outstanding-write flags (bit 0 always 0)
//   conflict_cnt               saturating count of cycles with >=2 requesters valid
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      sb_set_valid,
    input  logic [ADDR_W-1:0]         sb_set_addr,
    output logic [31:0]               sb_pending,
    output logic [15:0]               conflict_cnt
);

    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_set;
    logic [NUM_REGS-1:0] pend_clr;
    logic                multi_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are masked during reset so nothing is accepted while the
    // register file is reloading.
    assign req_ready = reset ? '0 : grant;
    assign accept    = |req_ready;
    assign sel_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Write stage: an accepted x0 write is consumed but never reaches the
    // register file; address/data hold when nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept && (sel_addr != ADDR_W'(REG_ZERO));
            if (accept && (sel_addr != ADDR_W'(REG_ZERO))) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    // Scoreboard: clear on the presented write, set from decode. Set is
    // OR-ed in after the clear so a same-edge set wins. Register 0 is never
    // touched because the loops start at 1.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (sb_set_valid && (sb_set_addr == ADDR_W'(r))) begin
                pend_set[r] = 1'b1;
            end
            if (wr_en && (wr_addr == ADDR_W'(r))) begin
                pend_clr[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    assign sb_pending = pend;

    assign multi_valid = ($countones(req_valid) >= 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (multi_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              sb_set_valid;
    logic [AW-1:0]     sb_set_addr;
    logic [31:0]       sb_pending;
    logic [15:0]       conflict_cnt;

    regfile_wb_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sb_set_valid (sb_set_valid),
        .sb_set_addr  (sb_set_addr),
        .sb_pending   (sb_pending),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int errors = 0;
    int checks = 0;

    // Reference model state, advanced at each falling edge to the value it
    // will have after the following rising edge.
    int          m_ptr = 0;
    bit [31:0]   m_pend = '0;
    int          m_cnt = 0;
    wr_t         exp_q[$];
    int          grant_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        int   g;
        int   j;
        logic [NR-1:0] exp_rdy;
        bit   cur_v;
        wr_t  it;
        wr_t  nw;
        if (reset) begin
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_wr_en", 64'(wr_en), 64'd0);
            check("rst_wr_addr", 64'(wr_addr), 64'd0);
            check("rst_wr_data", 64'(wr_data), 64'd0);
            check("rst_sb_pending", 64'(sb_pending), 64'd0);
            check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
            m_ptr  = 0;
            m_pend = '0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));

            cur_v = 1'b0;
            it.addr = '0;
            it.data = '0;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                cur_v = 1'b1;
            end
            check("wr_en", 64'(wr_en), 64'(cur_v));
            if (cur_v) begin
                check("wr_addr", 64'(wr_addr), 64'(it.addr));
                check("wr_data", 64'(wr_data), 64'(it.data));
            end
            check("sb_pending", 64'(sb_pending), 64'(m_pend));
            check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

            if (g >= 0) begin
                grant_log.push_back(g);
                m_ptr = (g + 1) % NR;
                nw.addr = req_addr[g*AW +: AW];
                nw.data = req_data[g*DW +: DW];
                if (nw.addr != 0) exp_q.push_back(nw);
            end
            if (cur_v) m_pend[it.addr] = 1'b0;
            if (sb_set_valid && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
            if ($countones(req_valid) >= 2 && m_cnt < 65535) m_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] acc;
        int r;
        int wcount;
        reset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        sb_set_valid = 1'b0;
        sb_set_addr = '0;
        step();
        step();
        reset = 1'b0;

        // Single ALU requester
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd5;
        req_data[0 +: DW] = 32'hDEAD_BEEF;
        #1;
        check("single_ready", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        check("single_wr_en", 64'(wr_en), 64'd1);
        check("single_wr_addr", 64'(wr_addr), 64'd5);
        check("single_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
        step();

        // Round-robin with all three valid
        do_reset();
        grant_log.delete();
        req_valid = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3333, 32'h2222, 32'h1111};
        repeat (6) step();
        req_valid = '0;
        check("rr_log_len", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check("rr_grant_order", 64'(grant_log[i]), 64'(i % 3));
        end
        check("rr_conflict_cnt", 64'(conflict_cnt), 64'd6);
        step();
        step();

        // x0 drop from load, and a set of r0
        req_valid = 3'b010;
        req_addr[AW +: AW] = 5'd0;
        req_data[DW +: DW] = 32'h1234;
        sb_set_valid = 1'b1;
        sb_set_addr = 5'd0;
        #1;
        check("x0_ready", 64'(req_ready), 64'b010);
        step();
        req_valid = '0;
        sb_set_valid = 1'b0;
        check("x0_wr_en", 64'(wr_en), 64'd0);
        check("x0_pending0", 64'(sb_pending[0]), 64'd0);
        step();

        // Scoreboard set/clear collision on r7
        do_reset();
        sb_set_valid = 1'b1;
        sb_set_addr = 5'd7;
        step();
        sb_set_valid = 1'b0;
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd7;
        req_data[0 +: DW] = 32'hA5A5_0007;
        step();
        req_valid = '0;
        sb_set_valid = 1'b1;
        sb_set_addr = 5'd7;
        step();
        sb_set_valid = 1'b0;
        check("collide_pending7", 64'(sb_pending[7]), 64'd1);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        step();
        step();
        check("clear_pending7", 64'(sb_pending[7]), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom % 3) != 0;
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            r = $urandom % 32;
            if (r != 0 && m_pend[r]) begin
                sb_set_valid = 1'b0;
            end else begin
                sb_set_valid = 1'($urandom % 2);
                sb_set_addr = AW'(r);
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        sb_set_valid = 1'b0;
        step();
        step();

        // Reset mid-stream with a write just accepted
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd9;
        req_data[0 +: DW] = 32'h0BAD_F00D;
        sb_set_valid = 1'b1;
        sb_set_addr = 5'd9;
        step();
        req_valid = '0;
        sb_set_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_pending", 64'(sb_pending), 64'd0);
        check("midrst_conflict", 64'(conflict_cnt), 64'd0);
        step();
        step();
        reset = 1'b0;
        wcount = 0;
        repeat (5) begin
            step();
            if (wr_en) wcount++;
        end
        check("midrst_no_write", 64'(wcount), 64'd0);

        // Conflict counter saturation
        do_reset();
        req_valid = 3'b011;
        req_addr = {5'd0, 5'd2, 5'd1};
        req_data = {32'h0, 32'hB2, 32'hA1};
        repeat (65540) step();
        check("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
        repeat (3) step();
        check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        req_valid = '0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between several write-back requesters (ALU, load unit, CSR/misc) using round-robin arbitration with a valid/ready handshake. It also keeps a 32-entry pending-write scoreboard that decode uses to detect RAW hazards. The block sits between the execution units and the register file's write_enable/write_address/write_data inputs, and registers the write one cycle after acceptance.

## Interface

**Parameters**
- NUM_REQ, default 3: number of write-back requesters. Index 0 = ALU, 1 = load, 2 = misc.
- ADDR_W, default 5: register address width.
- DATA_W, default 32: register data width.

**Ports**
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-hot grant. A request is accepted when req_valid[i] and req_ready[i] are both high.
- wr_en  out  1  register file write enable.
- wr_addr  out  ADDR_W  register file write address.
- wr_data  out  DATA_W  register file write data.
- sb_set_valid  in  1  decode has issued an instruction with destination sb_set_addr.
- sb_set_addr  in  ADDR_W  destination register to mark pending.
- sb_pending  out  32  bit r is high while register r has an outstanding write. Bit 0 is always 0.
- conflict_cnt  out  16  saturating count of cycles in which two or more req_valid bits were high.

## Operation

**Arbitration**
- Grant is combinational from req_valid and the round-robin pointer rr_ptr.
- Search order is rr_ptr, rr_ptr+1, … wrapping modulo NUM_REQ. The first valid requester is granted.
- At most one req_ready is high in any cycle. req_ready is 0 when the corresponding req_valid is 0.
- On each accepted grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- A requester must hold req_valid, req_addr and req_data stable until it is accepted.

**Write stage (one register level)**
- For an accepted request with addr ≠ 0, the next cycle has wr_en=1, wr_addr=addr, wr_data=data.
- For an accepted request with addr = 0, the request is accepted (ready pulses) but wr_en stays 0. The write is dropped.
- With no acceptance, the next cycle has wr_en=0. wr_addr and wr_data hold their previous values.

**Scoreboard**
- pend[r] is set on the edge where sb_set_valid=1 and sb_set_addr=r, for r ≠ 0.
- pend[r] is cleared on the edge where wr_en=1 and wr_addr=r.
- If set and clear target the same register on the same edge, set wins and the bit stays 1.
- Setting a bit that is already pending leaves it 1; the scoreboard does not count. Decode must not issue a second producer to a pending register. That is a protocol violation and its result is undefined.
- Writes to r0 and sets of r0 are ignored.

**conflict_cnt**
- Increments by 1 on each cycle with popcount(req_valid) ≥ 2.
- Saturates at 16'hFFFF.

## Timing

**Reset values** (asynchronous, immediate on reset):
- rr_ptr=0.
- wr_en=0, wr_addr=0, wr_data=0.
- pend=0, so sb_pending=0.
- conflict_cnt=0.

**Reset behaviour**
- req_ready is 0 while reset is high.
- Asserting reset mid-operation discards a write that has been accepted but not yet presented; it is never issued.
- The register file is reset in the same cycle and loads its own initial values. The arbiter does not drive writes during reset.

**Latency**
- Acceptance at edge N leads to wr_en high during cycle N+1, and the register file commits at edge N+1.
- The scoreboard clears at edge N+1, so sb_pending drops in cycle N+2.

**Throughput**
- One write per cycle, with back-to-back grants allowed.
- A single continuously-valid requester is granted every cycle.

## Structure

- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS=32, REG_ZERO=0;
  - requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MISC=2.
- Sub-module rr_arbiter, parameterised on NUM_REQ:
  - inputs: req vector, pointer;
  - outputs: one-hot grant and grant index.
- The write-stage register, scoreboard and conflict counter stay in the top module.

## Test plan

1. **Reset.** Assert reset mid-stream with a write just accepted. Required: wr_en=0 immediately, sb_pending=0, conflict_cnt=0, and no write to the register file after release.
2. **Single requester.** ALU holds valid with addr=5, data=32'hDEAD_BEEF. Required: req_ready[0] in cycle 0; wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF in cycle 1.
3. **Round-robin.** All three requesters are valid continuously with distinct addresses 1, 2, 3. Required: grants 0, 1, 2, 0, 1, 2 on consecutive cycles; conflict_cnt increments each cycle.
4. **x0 drop.** Load requests addr=0, data=32'h1234. Required: req_ready[1]=1 and wr_en=0 on the next cycle. Also sb_set to r0 leaves sb_pending[0]=0.
5. **Scoreboard collision.** Set r7 and, two cycles later, deliver the write to r7 while sb_set_valid also targets r7 on that same edge. Required: sb_pending[7] remains 1. A later write to r7 with no set clears it.
6. **Saturation.** Force two valids for 65540 cycles. Required: conflict_cnt=16'hFFFF and it holds.
